// File: rtl/pll_drp_sequencer.sv
// -----------------------------------------------------------------------------
// pll_drp_sequencer
//
// Runtime reconfiguration controller for a PLLE2_ADV over its DRP port.
// On start_i the PLL is held in reset, and a caller-supplied table of
// read-modify-write entries is applied one entry at a time. Reset is then
// released and the controller waits for LOCKED. Every wait has a timeout.
//
// Ports
//   clk_i         : clock, also the DRP DCLK (must not be a PLL output)
//   rst_i         : synchronous active-high reset
//   start_i       : request a reconfiguration (sampled only when idle)
//   busy_o        : sequence in progress
//   done_o        : one-cycle pulse at the end of a sequence (ok or error)
//   err_o         : status of the last sequence, 00 ok / 01 DRDY tmo / 10 lock tmo
//   tbl_idx_o     : current table index
//   tbl_addr_i    : DRP address of entry tbl_idx_o (combinational lookup)
//   tbl_mask_i    : bits to replace, 1 = take from tbl_data_i
//   tbl_data_i    : replacement bit values
//   tbl_last_i    : entry tbl_idx_o is the final one
//   drp_addr_o    : PLL DADDR
//   drp_en_o      : PLL DEN
//   drp_we_o      : PLL DWE
//   drp_di_o      : PLL DI
//   drp_do_i      : PLL DO
//   drp_rdy_i     : PLL DRDY
//   pll_rst_o     : PLL RST
//   pll_locked_i  : PLL LOCKED (asynchronous, synchronised internally)
// -----------------------------------------------------------------------------
module pll_drp_sequencer #(
   parameter int MAX_ENT  = 16,
   parameter int RST_HOLD = 4,
   parameter int DRDY_TMO = 64,
   parameter int LOCK_TMO = 65535,
   localparam int IDX_W   = (MAX_ENT > 1) ? $clog2(MAX_ENT) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [1:0]       err_o,
   output logic [IDX_W-1:0] tbl_idx_o,
   input  logic [6:0]       tbl_addr_i,
   input  logic [15:0]      tbl_mask_i,
   input  logic [15:0]      tbl_data_i,
   input  logic             tbl_last_i,
   output logic [6:0]       drp_addr_o,
   output logic             drp_en_o,
   output logic             drp_we_o,
   output logic [15:0]      drp_di_o,
   input  logic [15:0]      drp_do_i,
   input  logic             drp_rdy_i,
   output logic             pll_rst_o,
   input  logic             pll_locked_i
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   // One shared counter serves the reset hold and all timeouts, so it is
   // sized for the largest of them.
   localparam int TMO_A   = (LOCK_TMO > DRDY_TMO) ? LOCK_TMO : DRDY_TMO;
   localparam int TMO_MAX = (TMO_A > RST_HOLD) ? TMO_A : RST_HOLD;
   localparam int CNT_W   = $clog2(TMO_MAX + 1);

   // The counter is cleared in the request/release cycle and reads k-1 in the
   // k-th cycle after it, so a wait expires when it reads TMO-1.
   localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD);
   localparam logic [CNT_W-1:0] DRDY_END = CNT_W'(DRDY_TMO - 1);
   localparam logic [CNT_W-1:0] LOCK_END = CNT_W'(LOCK_TMO - 1);
   localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(MAX_ENT - 1);

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_DRDY = 2'b01;
   localparam logic [1:0] ERR_LOCK = 2'b10;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_HOLD      = 4'd1;
   localparam logic [3:0] S_RD_REQ    = 4'd2;
   localparam logic [3:0] S_RD_WAIT   = 4'd3;
   localparam logic [3:0] S_WR_REQ    = 4'd4;
   localparam logic [3:0] S_WR_WAIT   = 4'd5;
   localparam logic [3:0] S_NEXT      = 4'd6;
   localparam logic [3:0] S_RELEASE   = 4'd7;
   localparam logic [3:0] S_LOCK_WAIT = 4'd8;
   localparam logic [3:0] S_FINISH    = 4'd9;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   // Control state (reset)
   logic [3:0]       state_q,   state_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [1:0]       err_q,     err_d;
   logic             pll_rst_q, pll_rst_d;
   logic             last_q,    last_d;
   logic             lock_s1_q, lock_s1_d;
   logic             lock_s2_q, lock_s2_d;

   // Entry data (not reset; only ever observed after being loaded)
   logic [6:0]       addr_q,    addr_d;
   logic [15:0]      mask_q,    mask_d;
   logic [15:0]      data_q,    data_d;
   logic [15:0]      rd_q,      rd_d;

   logic [15:0]      merged;

   // Read-modify-write merge of the captured DO with the entry data.
   function automatic logic [15:0] rmw_merge(input logic [15:0] rd,
                                             input logic [15:0] mask,
                                             input logic [15:0] data);
      rmw_merge = (rd & ~mask) | (data & mask);
   endfunction

   assign merged = rmw_merge(rd_q, mask_q, data_q);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q + CNT_W'(1);
      err_d     = err_q;
      pll_rst_d = pll_rst_q;
      last_d    = last_q;
      addr_d    = addr_q;
      mask_d    = mask_q;
      data_d    = data_q;
      rd_d      = rd_q;
      lock_s1_d = pll_locked_i;
      lock_s2_d = lock_s1_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start_i) begin
               idx_d     = '0;
               err_d     = ERR_OK;
               pll_rst_d = 1'b1;
               state_d   = S_HOLD;
            end
         end

         S_HOLD: begin
            if (cnt_q == HOLD_END) begin
               state_d = S_RD_REQ;
            end
         end

         S_RD_REQ: begin
            // The table lookup is combinational on idx, so the entry is
            // captured here and used for the rest of this entry.
            addr_d  = tbl_addr_i;
            mask_d  = tbl_mask_i;
            data_d  = tbl_data_i;
            last_d  = tbl_last_i;
            cnt_d   = '0;
            state_d = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            // DRDY wins over a timeout expiring in the same cycle.
            if (drp_rdy_i) begin
               rd_d    = drp_do_i;
               state_d = S_WR_REQ;
            end else if (cnt_q == DRDY_END) begin
               err_d   = ERR_DRDY;
               state_d = S_RELEASE;
            end
         end

         S_WR_REQ: begin
            cnt_d   = '0;
            state_d = S_WR_WAIT;
         end

         S_WR_WAIT: begin
            if (drp_rdy_i) begin
               state_d = S_NEXT;
            end else if (cnt_q == DRDY_END) begin
               err_d   = ERR_DRDY;
               state_d = S_RELEASE;
            end
         end

         S_NEXT: begin
            if (last_q || (idx_q == IDX_END)) begin
               state_d = S_RELEASE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_RD_REQ;
            end
         end

         S_RELEASE: begin
            pll_rst_d = 1'b0;
            cnt_d     = '0;
            // After a DRP failure the PLL configuration is suspect, so lock
            // is not waited for.
            state_d   = (err_q != ERR_OK) ? S_FINISH : S_LOCK_WAIT;
         end

         S_LOCK_WAIT: begin
            if (lock_s2_q) begin
               state_d = S_FINISH;
            end else if (cnt_q == LOCK_END) begin
               err_d   = ERR_LOCK;
               state_d = S_FINISH;
            end
         end

         S_FINISH: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end

         default: begin
            cnt_d     = '0;
            pll_rst_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         err_q     <= ERR_OK;
         pll_rst_q <= 1'b0;
         last_q    <= 1'b0;
         lock_s1_q <= 1'b0;
         lock_s2_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         pll_rst_q <= pll_rst_d;
         last_q    <= last_d;
         lock_s1_q <= lock_s1_d;
         lock_s2_q <= lock_s2_d;
      end
   end

   always_ff @(posedge clk_i) begin
      addr_q <= addr_d;
      mask_q <= mask_d;
      data_q <= data_d;
      rd_q   <= rd_d;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // DRP outputs are decoded from the state so they are zero outside the two
   // request cycles, independent of the unreset entry registers.
   always_comb begin
      busy_o     = (state_q != S_IDLE);
      done_o     = (state_q == S_FINISH);
      drp_en_o   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
      drp_we_o   = (state_q == S_WR_REQ);
      drp_addr_o = '0;
      drp_di_o   = '0;
      if (state_q == S_RD_REQ) begin
         drp_addr_o = tbl_addr_i;
      end else if (state_q == S_WR_REQ) begin
         drp_addr_o = addr_q;
         drp_di_o   = merged;
      end
   end

   assign err_o     = err_q;
   assign tbl_idx_o = idx_q;
   assign pll_rst_o = pll_rst_q;

endmodule

// File: tb/tb_pll_drp_sequencer.sv
module tb_pll_drp_sequencer;

   localparam int MAX_ENT  = 4;
   localparam int RST_HOLD = 4;
   localparam int DRDY_TMO = 16;
   localparam int LOCK_TMO = 100;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        busy_o, done_o;
   logic [1:0]  err_o;
   logic [1:0]  tbl_idx_o;
   logic [6:0]  tbl_addr_i;
   logic [15:0] tbl_mask_i, tbl_data_i;
   logic        tbl_last_i;
   logic [6:0]  drp_addr_o;
   logic        drp_en_o, drp_we_o;
   logic [15:0] drp_di_o;
   logic [15:0] drp_do_i = 16'h0;
   logic        drp_rdy_i;
   logic        pll_rst_o;
   logic        pll_locked_i = 1'b0;

   always #5 clk = ~clk;

   // Table driven by the bench
   logic [6:0]  t_addr [4];
   logic [15:0] t_mask [4];
   logic [15:0] t_data [4];
   logic        t_last [4];
   assign tbl_addr_i = t_addr[tbl_idx_o];
   assign tbl_mask_i = t_mask[tbl_idx_o];
   assign tbl_data_i = t_data[tbl_idx_o];
   assign tbl_last_i = t_last[tbl_idx_o];

   // PLL DRP / lock model controls
   int          rd_lat = 1, wr_lat = 1, lock_lat = 10;
   logic        stray_rdy = 1'b0;
   logic        mdl_rdy = 1'b0;
   logic        pl_en = 1'b0;
   logic [6:0]  pl_addr = 7'h0;
   logic [15:0] pl_val = 16'h0;
   assign drp_rdy_i = mdl_rdy | stray_rdy;

   // Model state and observation
   logic [15:0] mem [128];
   int          pend = 0;
   logic [6:0]  pend_addr = 7'h0;
   int          en_cnt = 0, we_cnt = 0, rd_cnt = 0, done_cnt = 0, lock_cnt = 0;
   logic [6:0]  last_rd_addr = 7'h0, last_wr_addr = 7'h0;
   logic [15:0] last_wr_di = 16'h0;
   logic        rst_at_wr = 1'b0;
   logic [1:0]  idx_log [64];

   int n_checks = 0;
   int n_errors = 0;

   pll_drp_sequencer #(
      .MAX_ENT (MAX_ENT),
      .RST_HOLD(RST_HOLD),
      .DRDY_TMO(DRDY_TMO),
      .LOCK_TMO(LOCK_TMO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .tbl_idx_o   (tbl_idx_o),
      .tbl_addr_i  (tbl_addr_i),
      .tbl_mask_i  (tbl_mask_i),
      .tbl_data_i  (tbl_data_i),
      .tbl_last_i  (tbl_last_i),
      .drp_addr_o  (drp_addr_o),
      .drp_en_o    (drp_en_o),
      .drp_we_o    (drp_we_o),
      .drp_di_o    (drp_di_o),
      .drp_do_i    (drp_do_i),
      .drp_rdy_i   (drp_rdy_i),
      .pll_rst_o   (pll_rst_o),
      .pll_locked_i(pll_locked_i)
   );

   // DRP model: DRDY returns lat cycles after DEN (lat 0 = never).
   always @(posedge clk) begin
      int lat_v;
      mdl_rdy <= 1'b0;
      if (pl_en) mem[pl_addr] <= pl_val;
      if (drp_en_o) begin
         lat_v = drp_we_o ? wr_lat : rd_lat;
         en_cnt <= en_cnt + 1;
         if (drp_we_o) begin
            we_cnt       <= we_cnt + 1;
            mem[drp_addr_o] <= drp_di_o;
            last_wr_addr <= drp_addr_o;
            last_wr_di   <= drp_di_o;
            rst_at_wr    <= pll_rst_o;
         end else begin
            last_rd_addr    <= drp_addr_o;
            idx_log[rd_cnt] <= tbl_idx_o;
            rd_cnt          <= rd_cnt + 1;
         end
         pend_addr <= drp_addr_o;
         if (lat_v == 1) begin
            mdl_rdy  <= 1'b1;
            drp_do_i <= mem[drp_addr_o];
         end else if (lat_v > 1) begin
            pend <= lat_v - 1;
         end
      end else if (pend != 0) begin
         pend <= pend - 1;
         if (pend == 1) begin
            mdl_rdy  <= 1'b1;
            drp_do_i <= mem[pend_addr];
         end
      end
   end

   // Lock model: LOCKED rises lock_lat cycles after RST falls (0 = never).
   always @(posedge clk) begin
      if (pll_rst_o) begin
         lock_cnt     <= 0;
         pll_locked_i <= 1'b0;
      end else if (!pll_locked_i && lock_lat != 0) begin
         if (lock_cnt >= lock_lat - 1) pll_locked_i <= 1'b1;
         lock_cnt <= lock_cnt + 1;
      end
   end

   always @(posedge clk) if (done_o) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [6:0] a, input logic [15:0] v);
      pl_addr = a;
      pl_val  = v;
      pl_en   = 1'b1;
      tick();
      pl_en   = 1'b0;
   endtask

   task automatic set_ent(input int i, input logic [6:0] a, input logic [15:0] m,
                          input logic [15:0] d, input logic l);
      t_addr[i] = a;
      t_mask[i] = m;
      t_data[i] = d;
      t_last[i] = l;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_en(input int lim, output int n);
      n = 0;
      while (!drp_en_o && n < lim) begin
         tick();
         n++;
      end
      chk("den_within_bound", 32'(drp_en_o), 32'd1);
   endtask

   task automatic wait_done(input int lim, output int n, output int n_rel, output int n_lock);
      n = 0;
      n_rel = -1;
      n_lock = -1;
      while (!done_o && n < lim) begin
         tick();
         n++;
         if (n_rel < 0 && !pll_rst_o) n_rel = n;
         if (n_lock < 0 && pll_locked_i && !pll_rst_o) n_lock = n;
      end
      chk("done_within_bound", 32'(done_o), 32'd1);
   endtask

   initial begin
      int n, nr, nl, b_en, b_we, b_rd, b_done;
      for (int i = 0; i < 4; i++) set_ent(i, 7'h0, 16'h0, 16'h0, 1'b1);

      // Reset values
      repeat (3) tick();
      chk("rst_busy",    32'(busy_o),     32'd0);
      chk("rst_done",    32'(done_o),     32'd0);
      chk("rst_err",     32'(err_o),      32'd0);
      chk("rst_idx",     32'(tbl_idx_o),  32'd0);
      chk("rst_den",     32'(drp_en_o),   32'd0);
      chk("rst_dwe",     32'(drp_we_o),   32'd0);
      chk("rst_daddr",   32'(drp_addr_o), 32'd0);
      chk("rst_di",      32'(drp_di_o),   32'd0);
      chk("rst_pll_rst", 32'(pll_rst_o),  32'd0);
      rst_i = 1'b0;
      tick();

      // Stray DRDY in IDLE
      b_en = en_cnt; b_done = done_cnt;
      stray_rdy = 1'b1;
      tick();
      stray_rdy = 1'b0;
      repeat (3) tick();
      chk("stray_busy", 32'(busy_o), 32'd0);
      chk("stray_den",  32'(en_cnt - b_en), 32'd0);
      chk("stray_done", 32'(done_cnt - b_done), 32'd0);

      // Single entry, success
      set_ent(0, 7'h0E, 16'h0FFF, 16'h0041, 1'b1);
      preload(7'h0E, 16'hA3C3);
      rd_lat = 3; wr_lat = 3; lock_lat = 10;
      b_en = en_cnt; b_we = we_cnt; b_done = done_cnt;
      pulse_start();
      chk("t1_busy_c1",    32'(busy_o),    32'd1);
      chk("t1_pllrst_c1",  32'(pll_rst_o), 32'd1);
      wait_en(30, n);
      chk("t1_first_den_latency", 32'(n), 32'(RST_HOLD + 1));
      chk("t1_rd_addr", 32'(drp_addr_o), 32'h0E);
      chk("t1_rd_we",   32'(drp_we_o),   32'd0);
      tick();
      chk("t1_den_one_cycle", 32'(drp_en_o), 32'd0);
      wait_done(300, n, nr, nl);
      chk("t1_err",       32'(err_o),            32'd0);
      chk("t1_en_count",  32'(en_cnt - b_en),    32'd2);
      chk("t1_we_count",  32'(we_cnt - b_we),    32'd1);
      chk("t1_rd_addr_seen", 32'(last_rd_addr),  32'h0E);
      chk("t1_wr_addr",   32'(last_wr_addr),     32'h0E);
      chk("t1_wr_di",     32'(last_wr_di),       32'hA041);
      chk("t1_rst_at_wr", 32'(rst_at_wr),        32'd1);
      chk("t1_pllrst_done", 32'(pll_rst_o),      32'd0);
      chk("t1_lock_to_done", 32'(n - nl),        32'd3);
      tick();
      chk("t1_done_pulse_len", 32'(done_o), 32'd0);
      chk("t1_idle_busy",      32'(busy_o), 32'd0);
      chk("t1_done_count",     32'(done_cnt - b_done), 32'd1);

      // Three entries, last on entry 2, DRDY the cycle after DEN on reads
      set_ent(0, 7'h08, 16'hFFFF, 16'h5555, 1'b0);
      set_ent(1, 7'h09, 16'h00F0, 16'h00AB, 1'b0);
      set_ent(2, 7'h0A, 16'h8001, 16'hFFFF, 1'b1);
      set_ent(3, 7'h0B, 16'hFFFF, 16'h0000, 1'b0);
      preload(7'h08, 16'hFFFF);
      preload(7'h09, 16'h1234);
      preload(7'h0A, 16'h0000);
      rd_lat = 1; wr_lat = 2;
      b_en = en_cnt; b_we = we_cnt; b_rd = rd_cnt;
      pulse_start();
      wait_done(400, n, nr, nl);
      chk("t2_err",      32'(err_o),         32'd0);
      chk("t2_en_count", 32'(en_cnt - b_en), 32'd6);
      chk("t2_we_count", 32'(we_cnt - b_we), 32'd3);
      chk("t2_idx0",     32'(idx_log[b_rd]),     32'd0);
      chk("t2_idx1",     32'(idx_log[b_rd + 1]), 32'd1);
      chk("t2_idx2",     32'(idx_log[b_rd + 2]), 32'd2);
      chk("t2_mem08",    32'(mem[8]),  32'h5555);
      chk("t2_mem09",    32'(mem[9]),  32'h12A4);
      chk("t2_mem0a",    32'(mem[10]), 32'h8001);
      tick();

      // Table never asserts last; start pulsed while busy
      set_ent(0, 7'h10, 16'h00FF, 16'h0011, 1'b0);
      set_ent(1, 7'h11, 16'h00FF, 16'h0022, 1'b0);
      set_ent(2, 7'h12, 16'h00FF, 16'h0033, 1'b0);
      set_ent(3, 7'h13, 16'h00FF, 16'h0077, 1'b0);
      preload(7'h13, 16'hC300);
      rd_lat = 2; wr_lat = 1;
      b_en = en_cnt; b_we = we_cnt; b_rd = rd_cnt; b_done = done_cnt;
      pulse_start();
      repeat (20) tick();
      chk("t3_busy_mid", 32'(busy_o), 32'd1);
      pulse_start();
      wait_done(400, n, nr, nl);
      chk("t3_err",      32'(err_o),         32'd0);
      chk("t3_en_count", 32'(en_cnt - b_en), 32'd8);
      chk("t3_we_count", 32'(we_cnt - b_we), 32'd4);
      chk("t3_idx3",     32'(idx_log[b_rd + 3]), 32'd3);
      chk("t3_mem13",    32'(mem[19]), 32'hC377);
      repeat (10) tick();
      chk("t3_no_requeue_busy", 32'(busy_o), 32'd0);
      chk("t3_done_count", 32'(done_cnt - b_done), 32'd1);

      // DRDY never returns on the read
      set_ent(0, 7'h0E, 16'h0FFF, 16'h0041, 1'b1);
      rd_lat = 0; wr_lat = 1;
      b_en = en_cnt; b_we = we_cnt;
      pulse_start();
      wait_en(30, n);
      wait_done(100, n, nr, nl);
      chk("t4_done_latency", 32'(n), 32'(DRDY_TMO + 2));
      chk("t4_err",      32'(err_o),         32'd1);
      chk("t4_en_count", 32'(en_cnt - b_en), 32'd1);
      chk("t4_we_count", 32'(we_cnt - b_we), 32'd0);
      chk("t4_pllrst",   32'(pll_rst_o),     32'd0);
      repeat (5) tick();
      chk("t4_err_hold", 32'(err_o), 32'd1);

      // Lock never asserts
      rd_lat = 1; wr_lat = 1; lock_lat = 0;
      pulse_start();
      chk("t5_err_cleared", 32'(err_o), 32'd0);
      wait_done(400, n, nr, nl);
      chk("t5_release_to_done_window", 32'((n - nr) >= 99 && (n - nr) <= 104), 32'd1);
      chk("t5_err",    32'(err_o),     32'd2);
      chk("t5_pllrst", 32'(pll_rst_o), 32'd0);
      tick();

      // Reset while in WR_WAIT
      rd_lat = 2; wr_lat = 0; lock_lat = 10;
      b_done = done_cnt;
      pulse_start();
      n = 0;
      while (!(drp_en_o && drp_we_o) && n < 60) begin
         tick();
         n++;
      end
      chk("t6_write_issued", 32'(drp_we_o), 32'd1);
      repeat (2) tick();
      chk("t6_pllrst_before", 32'(pll_rst_o), 32'd1);
      rst_i = 1'b1;
      tick();
      chk("t6_pllrst_after", 32'(pll_rst_o), 32'd0);
      chk("t6_busy_after",   32'(busy_o),    32'd0);
      chk("t6_done_after",   32'(done_o),    32'd0);
      rst_i = 1'b0;
      repeat (5) tick();
      chk("t6_no_done", 32'(done_cnt - b_done), 32'd0);
      chk("t6_idle",    32'(busy_o),            32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
